ifetch: RTL and testbench

- Instruction fetch unit: owns the architectural fetch PC and a direct-mapped instruction cache, and refills the cache through the memory controller.
- Issues at most one instruction per cycle to the decoder over the inst_rdy / inst / inst_PC / inst_is_Jump interface.
- Applies static next-PC prediction and redirects on ROB rollback.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/ifetch_icache.sv | 56 +++++
 rtl/ifetch.sv | 125 ++++++++++++
 tb/tb_ifetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end.
// Opcodes, immediate decoders, fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    IDLE,
    MISS
  } fetch_state_e;

  function automatic logic [XLEN-1:0] imm_j(
    input logic [31:0] i
  );
    return {{12{i[31]}}, i[19:12], i[20],
            i[30:21], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(
    input logic [31:0] i
  );
    return {{20{i[31]}}, i[7], i[30:25],
            i[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_icache.sv
// Direct-mapped instruction cache, one word per line.
// Combinational lookup, synchronous fill, async valid clear.
module icache
  import riscv_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:2] rd_addr,
  output logic            hit,
  output logic [XLEN-1:0] rd_data,
  input  logic            wr_en,
  input  logic [XLEN-1:2] wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [XLEN-1:0]  data_q [LINES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;

  assign rd_idx = rd_addr[IDX_W+1:2];
  assign rd_tag = rd_addr[XLEN-1:IDX_W+2];
  assign wr_idx = wr_addr[IDX_W+1:2];
  assign wr_tag = wr_addr[XLEN-1:IDX_W+2];

  assign hit     = valid[rd_idx]
                && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  // valid bits: cleared on reset, set by a fill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // tag and data storage written on fill
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Fetch unit: PC, icache refill FSM, static predictor.
// IFETCH_BTFN_EN: predict backward branches taken.
module ifetch
  import riscv_pkg::*;
#(
  parameter int              ICACHE_IDX_W = 4,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            rollback,
  input  logic [XLEN-1:0] rollback_pc,
  input  logic            stall,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] mem_data,
  output logic            inst_rdy,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_PC,
  output logic            inst_is_Jump
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] line;
  logic [XLEN-1:0] next_pc;
  logic            hit;
  logic            taken;
  logic            fill;
  logic            is_jal;
`ifdef IFETCH_BTFN_EN
  logic            is_bwd;
`endif

  assign fill = rdy && (state == MISS)
             && mem_valid;

  icache #(
    .IDX_W (ICACHE_IDX_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (pc[XLEN-1:2]),
    .hit     (hit),
    .rd_data (line),
    .wr_en   (fill),
    .wr_addr (mem_addr[XLEN-1:2]),
    .wr_data (mem_data)
  );

  assign is_jal = (line[6:0] == OPC_JAL);
`ifdef IFETCH_BTFN_EN
  assign is_bwd = (line[6:0] == OPC_BRANCH)
               && line[31];
`endif

  // static next-PC prediction from the hit word
  always_comb begin
    next_pc = pc + 32'd4;
    taken   = 1'b0;
    unique case (1'b1)
      is_jal: begin
        next_pc = pc + imm_j(line);
        taken   = 1'b1;
      end
`ifdef IFETCH_BTFN_EN
      is_bwd: begin
        next_pc = pc + imm_b(line);
        taken   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // fetch FSM: issue on hit, refill on miss, redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      inst_rdy     <= 1'b0;
      inst         <= '0;
      inst_PC      <= '0;
      inst_is_Jump <= 1'b0;
    end else if (!rdy) begin
      inst_rdy <= 1'b0;
    end else begin
      inst_rdy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rollback) begin
            pc <= rollback_pc;
          end else if (stall) begin
            pc <= pc;
          end else if (hit) begin
            inst_rdy     <= 1'b1;
            inst         <= line;
            inst_PC      <= pc;
            inst_is_Jump <= taken;
            pc           <= next_pc;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {pc[XLEN-1:2], 2'b00};
            state    <= MISS;
          end
        end
        MISS: begin
          if (mem_valid) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
          if (rollback) begin
            pc <= rollback_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Randomized scoreboard bench for ifetch.
// Model walks the program stream; monitor compares issues.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        rollback = 1'b0;
  logic [31:0] rollback_pc = '0;
  logic        stall = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_PC;
  logic        inst_is_Jump;

  always #5 clk = ~clk;

  ifetch #(
    .ICACHE_IDX_W (4),
    .RESET_PC     (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .rollback     (rollback),
    .rollback_pc  (rollback_pc),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .inst_rdy     (inst_rdy),
    .inst         (inst),
    .inst_PC      (inst_PC),
    .inst_is_Jump (inst_is_Jump)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        jmp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem  [64];
  int          kind [64];
  int          off  [64];
  logic [31:0] mpc;
  int          tests  = 0;
  int          fails  = 0;
  int          issued = 0;
  bit          busy   = 0;
  int          lat    = 0;
  logic [31:0] resp_addr = '1;
  bit          fill_ok = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_j(input int o);
    logic [31:0] v;
    v = o;
    return {v[20], v[10:1], v[11], v[19:12],
            5'($urandom_range(0, 31)), 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input int o);
    logic [31:0] v;
    v = o;
    return {v[12], v[10:5],
            5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)),
            v[4:1], v[11], 7'b1100011};
  endfunction

  // reference: next instruction of the program stream
  function automatic void push_next();
    int   k;
    exp_t e;
    k     = int'(mpc[7:2]);
    e.pc  = mpc;
    e.ins = mem[k];
    e.jmp = 1'b0;
    mpc   = mpc + 32'd4;
    if (kind[k] == 1) begin
      e.jmp = 1'b1;
      mpc   = e.pc + 32'(off[k]);
    end
`ifdef IFETCH_BTFN_EN
    if (kind[k] == 2 && off[k] < 0) begin
      e.jmp = 1'b1;
      mpc   = e.pc + 32'(off[k]);
    end
`endif
    sb_q.push_back(e);
  endfunction

  function automatic void restart(input logic [31:0] p);
    sb_q.delete();
    mpc = p;
    while (sb_q.size() < 8) push_next();
  endfunction

  // monitor: pop and compare on every issued instruction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      fill_ok = 0;
    end else begin
      if (fill_ok && rdy && !rollback && !stall)
        chk("fill_to_issue", 32'(inst_rdy), 32'd1);
      fill_ok = mem_valid && rdy && !rollback
             && sb_q.size() > 0
             && resp_addr == sb_q[0].pc;
      if (inst_rdy) begin
        issued++;
        chk("issue_gate",
            32'({rollback, stall, !rdy}), 32'd0);
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("inst_PC", inst_PC, e.pc);
          chk("inst", inst, e.ins);
          chk("inst_is_Jump",
              32'(inst_is_Jump), 32'(e.jmp));
        end
      end
    end
  end

  // one cycle of stimulus plus the memory responder
  task automatic step(input int p_roll,
                      input int p_stall,
                      input int p_nrdy);
    @(negedge clk);
    mem_valid = 1'b0;
    if (busy) begin
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", mem_addr, resp_addr);
    end else if (mem_req) begin
      busy      = 1;
      lat       = int'($urandom_range(0, 3));
      resp_addr = mem_addr;
      chk("req_addr", mem_addr, sb_q[0].pc);
    end
    rdy = (p_nrdy == 0) ? 1'b1
        : ($urandom_range(0, p_nrdy - 1) != 0);
    stall = (p_stall != 0)
         && ($urandom_range(0, p_stall - 1) == 0);
    rollback = (p_roll != 0)
            && ($urandom_range(0, p_roll - 1) == 0);
    if (rollback) rollback_pc = $urandom & 32'h3FC;
    if (busy) begin
      if (lat > 0) begin
        lat--;
      end else if (rdy) begin
        mem_valid = 1'b1;
        mem_data  = mem[resp_addr[7:2]];
        busy      = 0;
      end
    end
    if (rollback && rdy) restart(rollback_pc);
    while (sb_q.size() < 8) push_next();
  endtask

  initial begin
    int o;
    int n;
    for (int i = 0; i < 64; i++) begin
      o = int'($urandom_range(1, 16)) * 4;
      if ($urandom_range(0, 1) == 1) o = -o;
      off[i] = o;
      n = int'($urandom_range(0, 9));
      if (n < 5) begin
        kind[i] = 0;
        mem[i]  = {$urandom, 7'b0}
                | 32'h0000_0013;
        mem[i][6:0] = 7'b0010011;
      end else if (n < 7) begin
        kind[i] = 1;
        mem[i]  = enc_j(o);
      end else if (n < 9) begin
        kind[i] = 2;
        mem[i]  = enc_b(o);
      end else begin
        kind[i] = 0;
        mem[i]  = $urandom;
        mem[i][6:0] = 7'b1100111;
      end
    end
    kind[0] = 0;  mem[0] = 32'h00100093;
    kind[1] = 0;  mem[1] = 32'h00208113;
    kind[2] = 1;  mem[2] = 32'h0100006F;
    off[2]  = 16;
    kind[8] = 2;  off[8] = -8;
    mem[8]  = enc_b(-8);

    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_inst_rdy", 32'(inst_rdy), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_PC", inst_PC, 32'd0);
    chk("rst_is_Jump", 32'(inst_is_Jump), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    restart(32'h0);
    repeat (60) step(0, 0, 0);
    repeat (3000) step(20, 5, 8);

    n = 0;
    while (!mem_req && n < 500) begin
      step(20, 5, 8);
      n++;
    end
    chk("miss_seen", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_inst_rdy", 32'(inst_rdy), 32'd0);
    mem_valid = 1'b0;
    rollback  = 1'b0;
    stall     = 1'b0;
    busy      = 0;
    resp_addr = '1;
    @(negedge clk);
    rst       = 1'b1;
    rdy       = 1'b1;
    mem_valid = 1'b1;
    mem_data  = 32'hDEADBEEF;
    restart(32'h0);
    step(0, 0, 0);
    chk("cold_miss", 32'(busy), 32'd1);
    chk("cold_addr", resp_addr, 32'h0);
    repeat (200) step(0, 0, 0);
    repeat (800) step(25, 6, 10);
    repeat (20) step(0, 0, 0);
    chk("issued_any", 32'(issued > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
